data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (cpu) and an auxiliary master (aux), e.g. a program loader or I/O DMA.
- Serialises accesses through a small FSM and drives the memory's write/read enables and word address.
- Stalls the pipeline while the cpu access is pending and acknowledges aux with a one-cycle pulse.
- Fixed cpu priority, with a starvation guard that forces an aux grant.

Parameters:
- ADDR_WIDTH, 12, byte-address bits used; word address = addr[ADDR_WIDTH-1:2].
- DATA_WIDTH, 32, data bus width.
- MEM_LATENCY, 1, cycles from read issue to mem_rdata valid (1..7).
- STARVE_LIMIT, 4, consecutive cpu grants while aux waits before aux is forced (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM-stage access request, held until cpu_stall drops.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data, valid in the cycle cpu_stall drops.
- cpu_stall  out  1  freeze the pipeline.
- aux_req, aux_we, aux_addr, aux_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  aux request, same semantics as cpu.
- aux_rdata  out  DATA_WIDTH  aux load data, valid with aux_ack.
- aux_ack  out  1  one-cycle completion pulse.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_addr  out  ADDR_WIDTH-2  word address to memory.
- mem_wdata  out  DATA_WIDTH  write data to memory.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE, owner=cpu, starve counter 0, latency counter 0.
  - All outputs 0, including cpu_rdata and aux_rdata.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE arbitration, evaluated every cycle:
  - Only cpu_req, or both with starve < STARVE_LIMIT: grant cpu.
  - Only aux_req, or both with starve == STARVE_LIMIT: grant aux.
  - Grant latches owner, we, address and wdata, then moves to ACCESS.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched values.
  - Write: mem_we=1 for exactly one cycle, then RESP.
  - Read: mem_re=1 throughout; stays MEM_LATENCY cycles, then captures mem_rdata into the owner's rdata register and moves to RESP.
- RESP (one cycle):
  - cpu owner: cpu_stall=0 and cpu_rdata valid.
  - aux owner: aux_ack=1.
  - Then IDLE; the next grant is possible in the following cycle.
- cpu_stall = cpu_req AND NOT (state==RESP AND owner==cpu). Combinational, so the stall rises in the same cycle cpu_req rises. A cpu write therefore stalls 2 cycles; a read stalls MEM_LATENCY+1 cycles.
- Starve counter:
  - Increments on a cpu grant while aux_req=1, saturating at STARVE_LIMIT.
  - Clears on an aux grant, and on any grant while aux_req=0.
- Rdata registers hold their value until the next read by the same owner.
- aux_req dropped before ack: the access already granted completes; the ack is still pulsed.
- cpu_req dropped mid-access (flush): the access completes and the stall deasserts; no error.
- Address bits [1:0] are ignored (word access only).
- Reset mid-access aborts immediately. A write already pulsed stays in memory; no partial retry.

Optional Feature:
- MEM_ARB_PERF_EN adds outputs:
  - perf_cpu_stall_cycles, 32-bit: counts cycles with cpu_stall=1.
  - perf_aux_grants, 16-bit: counts aux grants.
- Both counters wrap, and clear on reset.
- Without the macro, these ports and counters do not exist.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - owner encoding (OWNER_CPU=0, OWNER_AUX=1);
  - default widths.
- One natural sub-module: arb_starve_counter, a saturating counter with inc/clr/limit compare.

Test Plan:
- cpu read at addr 0x010, memory word 4 = 0xDEADBEEF, MEM_LATENCY=1 -> mem_re=1 with mem_addr=4; cpu_stall high 2 cycles; cpu_rdata=0xDEADBEEF when the stall drops.
- cpu write 0x12345678 to addr 0x020 -> single-cycle mem_we with mem_addr=8 and mem_wdata=0x12345678; stall 2 cycles.
- cpu_req and aux_req held continuously, STARVE_LIMIT=4 -> grant sequence cpu,cpu,cpu,cpu,aux,cpu...; aux_ack after the 4th cpu completion.
- aux write, then aux read at 0x100 -> aux_ack pulses once per access; aux_rdata returns the written value; cpu_stall stays 0 throughout.
- reset driven low during a read ACCESS -> all outputs 0 immediately and state IDLE; the next cpu read completes normally.
- Simultaneous request in IDLE with starve=0 -> cpu granted; starve becomes 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data memory arbiter.
// The optional MEM_ARB_PERF_EN build adds performance counters in data_mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_AUX = 1'b1;

    localparam int DEF_ADDR_WIDTH   = 12;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_MEM_LATENCY  = 1;
    localparam int DEF_STARVE_LIMIT = 4;

    localparam int STARVE_W = 4;
    localparam int LAT_W    = 3;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of cpu grants taken while aux was waiting.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT_V)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == LIMIT_V);

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter between the MEM stage (cpu) and an aux master.
// Define MEM_ARB_PERF_EN to add stall-cycle and aux-grant performance counters.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  aux_req,
    input  logic                  aux_we,
    input  logic [ADDR_WIDTH-1:0] aux_addr,
    input  logic [DATA_WIDTH-1:0] aux_wdata,
    output logic [DATA_WIDTH-1:0] aux_rdata,
    output logic                  aux_ack,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]           perf_cpu_stall_cycles,
    output logic [15:0]           perf_aux_grants,
`endif
    output logic                  busy
);

    // Requests are level-held until completion: cpu until cpu_stall drops,
    // aux until aux_ack pulses. A granted access always runs to completion.

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

    arb_state_t       state;
    logic             owner;
    logic             lat_we;
    logic [LAT_W-1:0] lat_cnt;

    logic                  grant_cpu;
    logic                  grant_aux;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  starve_at_limit;
    logic                  unused_addr_bits;

    assign grant_aux = (state == IDLE) && aux_req && (!cpu_req || starve_at_limit);
    assign grant_cpu = (state == IDLE) && cpu_req && !grant_aux;

    assign sel_we    = grant_aux ? aux_we    : cpu_we;
    assign sel_addr  = grant_aux ? aux_addr  : cpu_addr;
    assign sel_wdata = grant_aux ? aux_wdata : cpu_wdata;

    assign unused_addr_bits = ^{cpu_addr[1:0], aux_addr[1:0]};

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (grant_cpu && aux_req),
        .clr      (grant_aux || (grant_cpu && !aux_req)),
        .at_limit (starve_at_limit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= OWNER_CPU;
            lat_we    <= 1'b0;
            lat_cnt   <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            aux_rdata <= '0;
            aux_ack   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    aux_ack <= 1'b0;
                    if (grant_cpu || grant_aux) begin
                        owner     <= grant_aux ? OWNER_AUX : OWNER_CPU;
                        lat_we    <= sel_we;
                        lat_cnt   <= '0;
                        mem_addr  <= sel_addr[ADDR_WIDTH-1:2];
                        mem_wdata <= sel_wdata;
                        mem_we    <= sel_we;
                        mem_re    <= !sel_we;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        mem_we  <= 1'b0;
                        aux_ack <= (owner == OWNER_AUX);
                        state   <= RESP;
                    end else if (lat_cnt == LAT_LAST) begin
                        mem_re <= 1'b0;
                        if (owner == OWNER_AUX) begin
                            aux_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                        aux_ack <= (owner == OWNER_AUX);
                        state   <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                RESP: begin
                    aux_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    aux_ack <= 1'b0;
                    mem_we  <= 1'b0;
                    mem_re  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign cpu_stall = reset && cpu_req && !((state == RESP) && (owner == OWNER_CPU));
    assign busy      = (state != IDLE);

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cpu_stall_cycles <= '0;
            perf_aux_grants       <= '0;
        end else begin
            if (cpu_stall) begin
                perf_cpu_stall_cycles <= perf_cpu_stall_cycles + 32'd1;
            end
            if (grant_aux) begin
                perf_aux_grants <= perf_aux_grants + 16'd1;
            end
        end
    end
`endif

endmodule
